// File: rtl/timer_intc.sv
// Bus-attached 32-bit prescaled timer with a 3-source level interrupt controller.
// Single-cycle-latency target: an access is taken in IDLE and acknowledged in ACK.
module timer_intc #(
  parameter int AWIDTH = 3,
  parameter int PWIDTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [3:0]        sel_i,
  input  logic [AWIDTH-1:0] adr_i,
  input  logic [31:0]       dat_i,
  output logic [31:0]       dat_o,
  output logic              ack_o,
  output logic [2:0]        interrupts_o
);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  localparam logic [31:0] CTRL_BITS = 32'h0000_0073;

  state_t state_reg, state_next;
  logic   accept;

  logic [31:0]       ctrl_reg, ctrl_next;
  logic [2:0]        pend_reg, pend_next;
  logic [31:0]       count_reg, count_next;
  logic [31:0]       compare_reg, compare_next;
  logic [PWIDTH-1:0] prescale_reg, prescale_next;
  logic [PWIDTH-1:0] pcnt_reg, pcnt_next;
  logic [31:0]       dat_reg, dat_next;
  logic [2:0]        irq_reg;

  logic [31:0] wmask;
  logic [31:0] word;
  logic [31:0] rdata;
  logic        wr_ctrl, wr_status, wr_count, wr_compare, wr_prescale, wr_swint;
  logic        tick, match, reload, wrap, sw_set;
  logic [2:0]  pend_set, pend_clr;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wmask
      assign wmask[8*gi +: 8] = {8{sel_i[gi]}};
    end
  endgenerate

  // Handshake FSM: accept only in IDLE, so a held request is acked every other cycle.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cyc_i && stb_i) begin
          accept     = 1'b1;
          state_next = ACK;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign word        = 32'(adr_i);
  assign wr_ctrl     = accept && we_i && (word == 32'd0);
  assign wr_status   = accept && we_i && (word == 32'd1);
  assign wr_count    = accept && we_i && (word == 32'd2);
  assign wr_compare  = accept && we_i && (word == 32'd3);
  assign wr_prescale = accept && we_i && (word == 32'd4);
  assign wr_swint    = accept && we_i && (word == 32'd5);

  always_comb begin
    rdata = 32'd0;
    case (word)
      32'd0:   rdata = ctrl_reg;
      32'd1:   rdata = {29'd0, pend_reg};
      32'd2:   rdata = count_reg;
      32'd3:   rdata = compare_reg;
      32'd4:   rdata = 32'(prescale_reg);
      default: rdata = 32'd0;
    endcase
  end

  // Prescaler: free-runs only while enabled; a PRESCALE write does not restart it.
  assign tick = ctrl_reg[0] && (pcnt_reg == prescale_reg);

  always_comb begin
    pcnt_next = pcnt_reg + PWIDTH'(1);
    if (!ctrl_reg[0] || tick) begin
      pcnt_next = '0;
    end
  end

  assign match  = (count_reg == compare_reg);
  assign reload = match && ctrl_reg[1];
  assign wrap   = (count_reg == 32'hFFFF_FFFF) && !reload;

  // A bus write to COUNT overrides the tick update in the same cycle.
  always_comb begin
    count_next = count_reg;
    if (tick) begin
      count_next = reload ? 32'd0 : count_reg + 32'd1;
    end
    if (wr_count) begin
      count_next = (count_reg & ~wmask) | (dat_i & wmask);
    end
  end

  always_comb begin
    ctrl_next     = ctrl_reg;
    compare_next  = compare_reg;
    prescale_next = prescale_reg;
    if (wr_ctrl) begin
      ctrl_next = ((ctrl_reg & ~wmask) | (dat_i & wmask)) & CTRL_BITS;
    end
    if (wr_compare) begin
      compare_next = (compare_reg & ~wmask) | (dat_i & wmask);
    end
    if (wr_prescale) begin
      prescale_next = (prescale_reg & ~wmask[PWIDTH-1:0]) |
                      (dat_i[PWIDTH-1:0] & wmask[PWIDTH-1:0]);
    end
  end

  // Hardware/software sets are OR-ed in after the W1C clear, so a set always wins.
  assign sw_set    = wr_swint && dat_i[0] && sel_i[0];
  assign pend_set  = {sw_set, tick && wrap, tick && match};
  assign pend_clr  = wr_status ? (dat_i[2:0] & wmask[2:0]) : 3'b000;
  assign pend_next = (pend_reg & ~pend_clr) | pend_set;

  assign dat_next = (accept && !we_i) ? rdata : 32'd0;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg    <= IDLE;
      ctrl_reg     <= 32'd0;
      pend_reg     <= 3'b000;
      count_reg    <= 32'd0;
      compare_reg  <= 32'd0;
      prescale_reg <= '0;
      pcnt_reg     <= '0;
      dat_reg      <= 32'd0;
      irq_reg      <= 3'b000;
    end else begin
      state_reg    <= state_next;
      ctrl_reg     <= ctrl_next;
      pend_reg     <= pend_next;
      count_reg    <= count_next;
      compare_reg  <= compare_next;
      prescale_reg <= prescale_next;
      pcnt_reg     <= pcnt_next;
      dat_reg      <= dat_next;
      irq_reg      <= pend_next & ctrl_next[6:4];
    end
  end

  assign ack_o        = (state_reg == ACK);
  assign dat_o        = dat_reg;
  assign interrupts_o = irq_reg;

endmodule

// File: tb/tb_timer_intc.sv
// Directed bench for timer_intc: read data is scoreboarded (pushed on request,
// popped on ack); timer and interrupt timing is checked against edge-indexed expectations.
module tb_timer_intc;

  localparam logic [2:0] A_CTRL  = 3'd0;
  localparam logic [2:0] A_STAT  = 3'd1;
  localparam logic [2:0] A_COUNT = 3'd2;
  localparam logic [2:0] A_CMP   = 3'd3;
  localparam logic [2:0] A_PRE   = 3'd4;
  localparam logic [2:0] A_SWINT = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [2:0]  adr = 3'd0;
  logic [31:0] wdat = 32'd0;
  logic [31:0] rdat;
  logic        ack;
  logic [2:0]  irq;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int e0 = 0;
  logic [31:0] exp_q[$];

  timer_intc #(.AWIDTH(3), .PWIDTH(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cyc_i        (cyc),
    .stb_i        (stb),
    .we_i         (we),
    .sel_i        (sel),
    .adr_i        (adr),
    .dat_i        (wdat),
    .dat_o        (rdat),
    .ack_o        (ack),
    .interrupts_o (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic pop_cmp(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, rdat, e);
    end
  endtask

  task automatic goto(input int e);
    while (edge_n < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_dat", rdat, 32'd0);
    cyc = 1'b0; stb = 1'b0; rst = 1'b1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d; sel = s;
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    chk("wr_ack", 32'(ack), 32'd1);
    @(posedge clk);
    #1;
    chk("wr_ack_end", 32'(ack), 32'd0);
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] expv, input string tag);
    exp_q.push_back(expv);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; sel = 4'h0;
    chk({tag, "_ack"}, 32'(ack), 32'd1);
    if (ack === 1'b1) pop_cmp(tag);
    else void'(exp_q.pop_front());
    @(posedge clk);
    #1;
    chk({tag, "_ack_end"}, 32'(ack), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int js[4];
    int jexp[4];
    js   = '{3, 5, 7, 9};
    jexp = '{0, 1, 1, 2};

    // Reset with a request held, then every offset reads 0 with a single ack.
    do_reset();
    for (int i = 0; i < 8; i++) bus_read(3'(i), 32'd0, "rst_rd");

    // Byte-masked writes and unmapped/narrow registers.
    bus_write(A_CMP, 32'h1122_3344, 4'hF);
    bus_write(A_CMP, 32'hAABB_CCDD, 4'b0101);
    bus_read(A_CMP, 32'h11BB_33DD, "cmp_bytes");
    bus_write(3'd6, 32'hFFFF_FFFF, 4'hF);
    bus_read(3'd6, 32'd0, "off6");
    bus_write(A_PRE, 32'hFFFF_FFFF, 4'hF);
    bus_read(A_PRE, 32'h0000_FFFF, "pre_width");
    bus_write(A_CTRL, 32'hFFFF_FFFF, 4'hE);
    bus_read(A_CTRL, 32'd0, "ctrl_sel");
    bus_write(A_CTRL, 32'hFFFF_FFFF, 4'hF);
    bus_read(A_CTRL, 32'h0000_0073, "ctrl_bits");

    // Timer match with prescale 3: one tick every 4 cycles.
    do_reset();
    bus_write(A_PRE, 32'd3, 4'hF);
    bus_write(A_CMP, 32'd5, 4'hF);
    bus_write(A_CTRL, 32'h11, 4'hF);
    e0 = edge_n - 1;
    for (int k = 0; k < 4; k++) begin
      goto(e0 + js[k]);
      bus_read(A_COUNT, 32'(jexp[k]), "match_cnt");
    end
    goto(e0 + 23);
    chk("match_irq_before", 32'(irq), 32'd0);
    goto(e0 + 24);
    chk("match_irq", 32'(irq), 32'd1);
    bus_read(A_COUNT, 32'd6, "match_cnt_after");
    bus_write(A_STAT, 32'd1, 4'hF);
    chk("match_w1c_irq", 32'(irq), 32'd0);
    bus_read(A_STAT, 32'd0, "match_w1c_stat");

    // Auto-reload with prescale 0: COUNT cycles 0,1,2.
    do_reset();
    bus_write(A_PRE, 32'd0, 4'hF);
    bus_write(A_CMP, 32'd2, 4'hF);
    bus_write(A_CTRL, 32'h13, 4'hF);
    e0 = edge_n - 1;
    bus_read(A_COUNT, 32'd1, "ar_cnt1");
    bus_read(A_COUNT, 32'd0, "ar_cnt0");
    bus_read(A_COUNT, 32'd2, "ar_cnt2");
    bus_read(A_COUNT, 32'd1, "ar_cnt1b");
    goto(e0 + 11);
    bus_write(A_STAT, 32'd1, 4'hF);
    chk("ar_set_wins_irq", 32'(irq), 32'd1);
    bus_read(A_STAT, 32'd1, "ar_set_wins_stat");
    bus_write(A_STAT, 32'd1, 4'hF);
    chk("ar_clear_irq", 32'(irq), 32'd0);
    goto(e0 + 18);
    chk("ar_reset_irq", 32'(irq), 32'd1);

    // Overflow, then compare-match on the following tick.
    do_reset();
    bus_write(A_COUNT, 32'hFFFF_FFFE, 4'hF);
    bus_write(A_CMP, 32'd0, 4'hF);
    bus_write(A_PRE, 32'd0, 4'hF);
    bus_write(A_CTRL, 32'h21, 4'hF);
    e0 = edge_n - 1;
    chk("ovf_irq_before", 32'(irq), 32'd0);
    goto(e0 + 2);
    chk("ovf_irq", 32'(irq), 32'd2);
    bus_read(A_COUNT, 32'd0, "ovf_cnt");
    bus_read(A_STAT, 32'd3, "ovf_stat");
    chk("ovf_irq_masked", 32'(irq), 32'd2);
    bus_write(A_COUNT, 32'd100, 4'hF);
    bus_read(A_COUNT, 32'd101, "cnt_write_wins");

    // Software interrupt and a read request held high for 6 cycles.
    do_reset();
    bus_write(A_CTRL, 32'h40, 4'hF);
    bus_write(A_SWINT, 32'd1, 4'hE);
    chk("swint_sel0_off", 32'(irq), 32'd0);
    bus_write(A_SWINT, 32'd1, 4'hF);
    chk("swint_irq", 32'(irq), 32'd4);
    bus_read(A_SWINT, 32'd0, "swint_rd");
    for (int k = 0; k < 3; k++) exp_q.push_back(32'd4);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_STAT; sel = 4'hF;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      chk("held_ack", 32'(ack), 32'(k % 2));
      if (ack === 1'b1) pop_cmp("held_dat");
    end
    cyc = 1'b0; stb = 1'b0; sel = 4'h0;
    chk("held_ack_count", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
